// File: rtl/memio_read_unit.sv
// rtl/memio_read_unit.sv - load-side reader: memory / switch-port decode, multi-cycle read, lane extract and extend
module memio_read_unit #(
    parameter int          MEM_LAT = 1,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int          SW_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_req,
    input  logic [31:0]     addr,
    input  logic [2:0]      ld_type,
    input  logic [SW_W-1:0] switch,
    output logic            mem_en,
    output logic [13:0]     mem_addr,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     r_wdata,
    output logic            rd_valid,
    output logic            busy,
    output logic            misalign
);

    typedef enum logic [2:0] {IDLE, MEM_ISSUE, MEM_WAIT, IO_RD, DONE} state_t;

    // MEM_WAIT lasts cnt+1 cycles, giving MEM_LAT-1 wait cycles in total
    localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_t          state, state_nxt;
    logic [1:0]      lane_q, lane_nxt;
    logic [2:0]      type_q, type_nxt;
    logic [1:0]      cnt, cnt_nxt;
    logic [SW_W-1:0] sw_meta, sw_sync;
    logic            mem_en_nxt, rd_valid_nxt, misalign_nxt;
    logic [13:0]     mem_addr_nxt;
    logic [31:0]     r_wdata_nxt, io_word;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lane, input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lane[0];
            default:        return lane != 2'b00;
        endcase
    endfunction

    assign busy = (state == MEM_ISSUE) || (state == MEM_WAIT) || (state == IO_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lane_q   <= 2'b00;
            type_q   <= 3'b000;
            cnt      <= 2'b00;
            sw_meta  <= '0;
            sw_sync  <= '0;
            mem_en   <= 1'b0;
            mem_addr <= 14'd0;
            r_wdata  <= 32'd0;
            rd_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            lane_q   <= lane_nxt;
            type_q   <= type_nxt;
            cnt      <= cnt_nxt;
            sw_meta  <= switch;
            sw_sync  <= sw_meta;
            mem_en   <= mem_en_nxt;
            mem_addr <= mem_addr_nxt;
            r_wdata  <= r_wdata_nxt;
            rd_valid <= rd_valid_nxt;
            misalign <= misalign_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lane_nxt     = lane_q;
        type_nxt     = type_q;
        cnt_nxt      = cnt;
        mem_en_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        r_wdata_nxt  = r_wdata;
        rd_valid_nxt = 1'b0;
        misalign_nxt = 1'b0;
        io_word      = '0;
        io_word[SW_W-1:0] = sw_sync;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (rd_req) begin
                    lane_nxt     = addr[1:0];
                    type_nxt     = ld_type;
                    mem_addr_nxt = addr[15:2];
                    if (is_misaligned(addr[1:0], ld_type)) begin
                        state_nxt    = DONE;
                        r_wdata_nxt  = 32'd0;
                        rd_valid_nxt = 1'b1;
                        misalign_nxt = 1'b1;
                    end else if (addr >= IO_BASE) begin
                        state_nxt = IO_RD;
                    end else begin
                        state_nxt  = MEM_ISSUE;
                        mem_en_nxt = 1'b1;
                    end
                end
            end
            MEM_ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_nxt    = DONE;
                    r_wdata_nxt  = extract(mem_rdata, lane_q, type_q);
                    rd_valid_nxt = 1'b1;
                end else begin
                    state_nxt = MEM_WAIT;
                    cnt_nxt   = WAIT_INIT;
                end
            end
            MEM_WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt    = DONE;
                    r_wdata_nxt  = extract(mem_rdata, lane_q, type_q);
                    rd_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            IO_RD: begin
                state_nxt    = DONE;
                r_wdata_nxt  = extract(io_word, lane_q, type_q);
                rd_valid_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memio_read_unit.sv
// tb/tb_memio_read_unit.sv - directed scoreboard bench for memio_read_unit (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_memio_read_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req1, rd_req3;
    logic [31:0] addr;
    logic [2:0]  ld_type;
    logic [15:0] switch;
    logic [31:0] mem_rdata;

    logic        mem_en1, rd_valid1, busy1, misalign1;
    logic [13:0] mem_addr1;
    logic [31:0] r_wdata1;
    logic        mem_en3, rd_valid3, busy3, misalign3;
    logic [13:0] mem_addr3;
    logic [31:0] r_wdata3;

    logic        sel;
    logic        o_mem_en, o_rd_valid, o_busy, o_misalign;
    logic [13:0] o_mem_addr;
    logic [31:0] o_r_wdata;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [32:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    memio_read_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req1), .addr(addr), .ld_type(ld_type),
        .switch(switch), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata),
        .r_wdata(r_wdata1), .rd_valid(rd_valid1), .busy(busy1), .misalign(misalign1)
    );

    memio_read_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req3), .addr(addr), .ld_type(ld_type),
        .switch(switch), .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata),
        .r_wdata(r_wdata3), .rd_valid(rd_valid3), .busy(busy3), .misalign(misalign3)
    );

    assign o_mem_en   = sel ? mem_en3   : mem_en1;
    assign o_rd_valid = sel ? rd_valid3 : rd_valid1;
    assign o_busy     = sel ? busy3     : busy1;
    assign o_misalign = sel ? misalign3 : misalign1;
    assign o_mem_addr = sel ? mem_addr3 : mem_addr1;
    assign o_r_wdata  = sel ? r_wdata3  : r_wdata1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v);
        if (sel) rd_req3 = v;
        else     rd_req1 = v;
    endtask

    // single load with request pulsed for one cycle; expectations pushed before driving
    task automatic load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d,
                        input logic mis, input int lat, input int n_memen, input int n_busy);
        int          cyc, memen_c, busy_c, el;
        logic [32:0] e;
        @(negedge clk);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
        addr = a;
        ld_type = t;
        set_req(1'b1);
        exp_q.push_back({mis, d});
        lat_q.push_back(lat);
        @(posedge clk);
        #1;
        set_req(1'b0);
        cyc = 1;
        memen_c = 0;
        busy_c = 0;
        while (!o_rd_valid && cyc < 20) begin
            if (o_mem_en) begin
                memen_c++;
                chk("mem_addr", {18'd0, o_mem_addr}, {18'd0, a[15:2]});
            end
            if (o_busy) busy_c++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rd_valid_seen", {31'd0, o_rd_valid}, 32'd1);
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (o_rd_valid) begin
            chk("latency", cyc, el);
            chk("r_wdata", o_r_wdata, e[31:0]);
            chk("misalign", {31'd0, o_misalign}, {31'd0, e[32]});
            chk("done_busy", {31'd0, o_busy}, 32'd0);
        end
        chk("mem_en_cycles", memen_c, n_memen);
        chk("busy_cycles", busy_c, n_busy);
        @(posedge clk);
        #1;
        chk("rd_valid_drop", {31'd0, o_rd_valid}, 32'd0);
        chk("r_wdata_hold", o_r_wdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          memen_c, busy_c, nvalid, vc0, vc1, stray;
        logic [32:0] e;

        rst_n = 1'b0;
        rd_req1 = 1'b0;
        rd_req3 = 1'b0;
        sel = 1'b0;
        addr = 32'd0;
        ld_type = 3'b000;
        switch = 16'd0;
        mem_rdata = 32'd0;
        #2;
        chk("rst_flags1", {28'd0, mem_en1, rd_valid1, busy1, misalign1}, 32'd0);
        chk("rst_addr1", {18'd0, mem_addr1}, 32'd0);
        chk("rst_data1", r_wdata1, 32'd0);
        chk("rst_flags3", {28'd0, mem_en3, rd_valid3, busy3, misalign3}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // MEM_LAT=1 memory loads
        mem_rdata = 32'hDEAD_BEEF;
        load(32'h0000_0010, 3'b010, 32'hDEAD_BEEF, 1'b0, 2, 1, 1);
        mem_rdata = 32'h8081_7F80;
        load(32'h0000_0103, 3'b000, 32'hFFFF_FF80, 1'b0, 2, 1, 1);
        load(32'h0000_0103, 3'b100, 32'h0000_0080, 1'b0, 2, 1, 1);
        load(32'h0000_0102, 3'b001, 32'hFFFF_8081, 1'b0, 2, 1, 1);
        load(32'h0000_0100, 3'b101, 32'h0000_7F80, 1'b0, 2, 1, 1);
        load(32'h0000_0101, 3'b000, 32'h0000_007F, 1'b0, 2, 1, 1);
        load(32'h0000_0104, 3'b111, 32'h8081_7F80, 1'b0, 2, 1, 1);

        // switch port
        switch = 16'hA5C3;
        repeat (3) @(posedge clk);
        load(32'hFFFF_FC70, 3'b010, 32'h0000_A5C3, 1'b0, 2, 0, 1);
        load(32'hFFFF_FC71, 3'b000, 32'hFFFF_FFA5, 1'b0, 2, 0, 1);

        // misaligned
        load(32'h0000_0012, 3'b010, 32'h0000_0000, 1'b1, 1, 0, 0);
        load(32'h0000_0013, 3'b101, 32'h0000_0000, 1'b1, 1, 0, 0);

        // MEM_LAT=3, request held across two loads
        sel = 1'b1;
        @(negedge clk);
        addr = 32'h0000_0040;
        ld_type = 3'b010;
        mem_rdata = 32'h1111_2222;
        rd_req3 = 1'b1;
        exp_q.push_back({1'b0, 32'h1111_2222});
        exp_q.push_back({1'b0, 32'h3333_4444});
        @(posedge clk);
        #1;
        memen_c = 0;
        busy_c = 0;
        nvalid = 0;
        vc0 = 0;
        vc1 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (mem_en3) memen_c++;
            if (busy3) busy_c++;
            if (rd_valid3) begin
                nvalid++;
                if (nvalid == 1) vc0 = cyc;
                if (nvalid == 2) vc1 = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_r_wdata", r_wdata3, e[31:0]);
                end
            end
            if (cyc == 4) mem_rdata = 32'h3333_4444;
            if (cyc == 5) rd_req3 = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("b2b_valid_count", nvalid, 2);
        chk("b2b_first_lat", vc0, 4);
        chk("b2b_second_cyc", vc1, 8);
        chk("b2b_mem_en", memen_c, 2);
        chk("b2b_busy", busy_c, 6);
        exp_q.delete();

        // asynchronous reset during MEM_WAIT
        @(negedge clk);
        addr = 32'h0000_0040;
        ld_type = 3'b010;
        rd_req3 = 1'b1;
        @(posedge clk);
        #1;
        rd_req3 = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy3}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {28'd0, mem_en3, rd_valid3, busy3, misalign3}, 32'd0);
        chk("arst_addr", {18'd0, mem_addr3}, 32'd0);
        chk("arst_data", r_wdata3, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rd_valid3) stray++;
        end
        chk("no_stray_valid", stray, 0);

        mem_rdata = 32'h8081_7F80;
        load(32'h0000_0042, 3'b101, 32'h0000_8081, 1'b0, 4, 1, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memio_read_unit.md
# memio_read_unit

Load-side data source for the writeback path. Accepts a load request from the execute stage and decodes the address into data memory or the memory-mapped switch port. Performs a multi-cycle read with a busy/valid handshake, then byte/half-word extracts and sign- or zero-extends the result. The registered result drives the `r_wdata` input of the writeback selector; `busy` stalls the pipeline while a read is outstanding.

## Interface
Parameters:
- `MEM_LAT`, 1: data-memory read latency in cycles, from the `mem_en` sample edge to `mem_rdata` valid; legal range 1..4.
- `IO_BASE`, 32'hFFFF_FC00: addresses `>= IO_BASE` select the IO (switch) path.
- `SW_W`, 16: switch bus width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rd_req`  in  1  load request; sampled only when `busy`=0.
- `addr`  in  32  byte address of the load.
- `ld_type`  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes are treated as lw.
- `switch`  in  SW_W  raw asynchronous switch inputs.
- `mem_en`  out  1  data-memory read enable; registered.
- `mem_addr`  out  14  word address = latched `addr[15:2]`; registered.
- `mem_rdata`  in  32  data-memory read data.
- `r_wdata`  out  32  extended load result; registered.
- `rd_valid`  out  1  one-cycle pulse: `r_wdata` is valid for the current load.
- `busy`  out  1  a load is in flight; the pipeline must hold.
- `misalign`  out  1  one-cycle pulse coincident with `rd_valid` when the load was misaligned.

## Operation
- FSM states: IDLE, MEM_ISSUE, MEM_WAIT, IO_RD, DONE.
- `busy` = 1 in MEM_ISSUE, MEM_WAIT and IO_RD; `busy` = 0 in IDLE and DONE.
- Request acceptance:
  - Accepted at a rising edge with `rd_req`=1 and state IDLE or DONE.
  - `addr` and `ld_type` are latched on acceptance.
  - `rd_req` while `busy`=1 is ignored; no queuing.
- Misaligned load (lw with `addr[1:0]`≠0; lh/lhu with `addr[0]`=1):
  - Next state DONE; no memory or IO access.
  - `r_wdata` = 0; `misalign` = 1.
- IO path (aligned, `addr >= IO_BASE`):
  - Next state IO_RD, then DONE.
  - The loaded word is the synchronized switch value zero-extended to 32 bits, then extracted per `ld_type` the same way as memory.
- Memory path (aligned, `addr < IO_BASE`):
  - Next state MEM_ISSUE, with `mem_en`=1 for exactly that one cycle.
  - MEM_WAIT counts down `MEM_LAT`−1 further cycles (0 when `MEM_LAT`=1).
  - `mem_rdata` is captured at the edge leaving the final wait cycle, with the next state DONE.
- Extraction (little-endian):
  - Bytes use lane `addr[1:0]`; half-words use lane `addr[1]`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- DONE: `rd_valid`=1 for one cycle, then IDLE unless a new request is accepted in the same cycle.
- `r_wdata` holds its last value between loads.
- Switch synchronizer: two flops, both reset to 0.

## Timing
- Reset values: `mem_en`=0, `mem_addr`=0, `r_wdata`=0, `rd_valid`=0, `busy`=0, `misalign`=0, state IDLE, synchronizer flops 0.
- Reset asserted mid-load: the load is aborted immediately (asynchronously) and all outputs take their reset values. No `rd_valid` is produced for the aborted load.
- Latency from the acceptance edge to the `rd_valid` cycle:
  - misaligned: 1 cycle
  - IO: 2 cycles
  - memory: `MEM_LAT`+1 cycles
- Back-to-back loads: a request accepted in the DONE cycle starts the next load without an IDLE bubble. Maximum throughput for `MEM_LAT`=1 is one memory load every 2 cycles.
- Switch-to-`r_wdata` latency: 2 synchronizer cycles plus the IO load latency.

## Test plan
- Reset, then an lw from `addr`=0x0000_0010 with `mem_rdata`=0xDEAD_BEEF, `MEM_LAT`=1:
  - `mem_en` pulses for one cycle with `mem_addr`=4.
  - `rd_valid` pulses 2 cycles after acceptance with `r_wdata`=0xDEAD_BEEF.
  - `busy` is high for exactly 1 cycle.
- Word 0x8081_7F80, each load run separately:
  - lb at offset 3 → 0xFFFF_FF80
  - lbu at offset 3 → 0x0000_0080
  - lh at offset 2 → 0xFFFF_8081
  - lhu at offset 0 → 0x0000_7F80
- `switch`=0xA5C3 held for at least 3 cycles, then lw from 0xFFFF_FC70: `rd_valid` pulses 2 cycles after acceptance with `r_wdata`=0x0000_A5C3 and `mem_en` stays 0.
- lw from 0x0000_0012 → next cycle `rd_valid`=`misalign`=1, `r_wdata`=0, `mem_en` never asserted.
- With `MEM_LAT`=3, request held continuously across two loads:
  - First `rd_valid` arrives 4 cycles after acceptance.
  - The second load is accepted in that DONE cycle and its `rd_valid` arrives 4 cycles later.
  - `rd_req` during busy cycles causes no extra accesses.
- `rst_n` pulled low during MEM_WAIT:
  - All outputs go to 0 with no clock edge.
  - After release, no `rd_valid` is produced until a new request is accepted.
